pic_cmd_decoder: RTL and testbench
==================================

# pic_cmd_decoder

Synchronous, parametrised command decoder for the PIC: it captures host bus writes, runs the ICW1–ICW4 initialisation sequence, decodes OCW1–OCW3, and drives configuration/command outputs to the control logic. It also tracks which register a host read returns. It adds three features: single-clock registered operation, an IRQ_W-wide mask loaded over multiple OCW1 bytes, and one-shot poll handling with sequence-error reporting.

## Interface
- IRQ_W, 8, interrupt line count / IMR width; a multiple of 8 in the range 8..32; NB = IRQ_W/8 OCW1 bytes
- clk  in  1  single clock; all bus inputs are synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- cs_n, rd_n, wr_n  in  1 each  active-low chip select, read strobe, write strobe
- a0  in  1  register address bit
- din  in  8  write data
- init_done  out  1  high in READY
- vec_base  out  5  ICW2[7:3]
- sngl, ic4, ltim  out  1 each  ICW1 D1, D0, D3
- icw3  out  8  cascade word
- icw4  out  5  ICW4[4:0]
- imr  out  IRQ_W  interrupt mask
- ocw2_cmd  out  8  last OCW2 byte
- ocw2_valid  out  1  one-cycle pulse
- smm  out  1  special mask mode
- poll_req  out  1  one-cycle pulse
- rd_sel  out  2  read source: 00 IRR, 01 ISR, 10 IMR, 11 POLL
- seq_err  out  1  one-cycle pulse on a rejected write

## Operation
- Write event: a registered falling edge of wr_n while cs_n=0 and rd_n=1. Read event: a registered falling edge of rd_n while cs_n=0 and wr_n=1. An edge with both strobes low is ignored.
- ICW1 is a write with a0=0 and din[4]=1. It is accepted in any state and does the following:
  - loads sngl, ic4 and ltim;
  - clears imr, smm, icw3 and icw4;
  - sets the base read select to IRR and clears the OCW1 byte index;
  - moves the FSM to W_ICW2.
- FSM states: IDLE (after reset), W_ICW2, W_ICW3, W_ICW4, READY.
- W_ICW2: a write with a0=1 loads vec_base. The FSM then goes to W_ICW3 if sngl=0, else to W_ICW4 if ic4=1, else to READY.
- W_ICW3: a write with a0=1 loads icw3. The FSM then goes to W_ICW4 if ic4=1, else to READY.
- W_ICW4: a write with a0=1 loads icw4 and the FSM goes to READY.
- Rejected writes, each of which pulses seq_err and changes no other state:
  - any non-ICW1 write in IDLE;
  - any write with a0=0 that is not ICW1 in a W_ state.
- READY, a0=1 (OCW1): din is written to imr[8k+7:8k], where k is the byte index. k then increments modulo NB.
- READY, a0=0, din[4:3]=00 (OCW2): ocw2_cmd is loaded with din and ocw2_valid pulses.
- READY, a0=0, din[4:3]=01 (OCW3):
  - din[6]=1: smm is set to din[5]; din[6]=0 leaves smm unchanged;
  - din[1]=1: the base select is set to ISR if din[0]=1, else IRR;
  - din[2]=1: poll_req pulses and a poll is armed.
- Any write with a0=0 resets k to 0.
- rd_sel = 10 (IMR) whenever a0=1. Otherwise it is 11 if a poll is armed, else the base select.
- A read event with a0=0 and a poll armed disarms the poll (one-shot); rd_sel then returns to the base select.
- Read events never change any other state.

## Timing
- Strobe inputs are registered once for edge detection. State and outputs update at the clock edge ending the cycle in which the edge is detected, so they are visible in the next cycle, one cycle after the strobe falls.
- ocw2_valid, poll_req and seq_err are high for exactly one cycle per event.
- rd_sel is combinational from a0 and registered state. It is valid while rd_n is low.
- Values after reset (rst_n low, asynchronous):
  - FSM in IDLE, init_done=0;
  - all data outputs 0;
  - base select IRR, rd_sel=00, poll disarmed, k=0;
  - all pulses low.
- Reset deasserted mid-sequence: the block requires a new ICW1 before it accepts anything.
- ICW1 while READY: the block re-initialises. imr is cleared in the same update.
- OCW1 with NB=1: k stays 0, and every OCW1 write overwrites the whole imr.
- A strobe held low generates one event only. A new event needs the strobe to return high for at least one cycle.

## Test plan
- Reset, then ICW1=0x13 (sngl=1, ic4=1), ICW2=0x20, ICW4=0x01 -> vec_base=0x04, icw4=0x01, init_done=1 one cycle after the third write.
- IRQ_W=16: cascade init ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x01, then OCW1 0xAA, 0x55 -> icw3=0x04, imr=0x55AA. A third OCW1 0xFF -> imr=0x55FF.
- READY: OCW2 0x20 -> ocw2_valid high one cycle, ocw2_cmd=0x20. OCW3 0x0B -> rd_sel=01 for a0=0 and rd_sel=10 for a0=1.
- OCW3 0x0C, then a read with a0=0 -> poll_req pulses once, rd_sel=11 during that read, and rd_sel returns to the prior base select afterwards. OCW3 0x68 -> smm=1.
- IDLE: write a0=1 0xFF -> seq_err pulses and imr stays 0. In W_ICW2: write a0=0 0x08 -> seq_err pulses and the FSM stays in W_ICW2.
- Assert rst_n low during W_ICW3 -> all outputs reach their reset values immediately. Both strobes low together -> no state change.

Source files
------------

// File: rtl/pic_cmd_decoder_if.sv
// Host bus of the PIC command decoder: chip select, strobes, address, write data and read-source select.
// No latency of its own; it only groups the signals. rd_sel is combinational in the decoder.
// No backpressure: the host owns the strobes and the decoder never stalls the bus.
interface pic_cmd_decoder_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic [1:0] rd_sel;

  modport master (output cs_n, rd_n, wr_n, a0, din, input rd_sel);
  modport slave  (input cs_n, rd_n, wr_n, a0, din, output rd_sel);
endinterface

// File: rtl/pic_cmd_decoder.sv
// PIC command decoder: runs the ICW1-ICW4 initialisation sequence, decodes OCW1-OCW3 and tracks the read source.
// Latency: a strobe falling edge is detected one cycle after it falls. Results are visible right after that edge.
// No backpressure: every valid write is taken at once. Writes that arrive out of sequence are dropped and flagged on seq_err.
module pic_cmd_decoder #(
  parameter int IRQ_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pic_cmd_decoder_if.slave  bus,
  output logic              init_done,
  output logic [4:0]        vec_base,
  output logic              sngl,
  output logic              ic4,
  output logic              ltim,
  output logic [7:0]        icw3,
  output logic [4:0]        icw4,
  output logic [IRQ_W-1:0]  imr,
  output logic [7:0]        ocw2_cmd,
  output logic              ocw2_valid,
  output logic              smm,
  output logic              poll_req,
  output logic              seq_err
);

  localparam int NB = IRQ_W / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  typedef enum logic [2:0] {IDLE, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

  state_t        state, state_nxt;
  logic          wr_q, rd_q;
  logic          wr_ev, rd_ev, icw1;
  logic          rej, ld_icw2, ld_icw3, ld_icw4, ocw1, ocw2, ocw3;
  logic          base_isr;
  logic          poll_armed;
  logic [KW-1:0] k;

  // Edge detection: an event needs the strobe high in the previous cycle and the other strobe idle now.
  assign wr_ev = wr_q & ~bus.wr_n & ~bus.cs_n & bus.rd_n;
  assign rd_ev = rd_q & ~bus.rd_n & ~bus.cs_n & bus.wr_n;
  assign icw1  = wr_ev & ~bus.a0 & bus.din[4];

  assign init_done  = (state == READY);
  assign bus.rd_sel = bus.a0 ? 2'b10 : (poll_armed ? 2'b11 : {1'b0, base_isr});

  // Registered copies of the strobes, used for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b1;
      rd_q <= 1'b1;
    end else begin
      wr_q <= bus.wr_n;
      rd_q <= bus.rd_n;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Each write is classified as ICW load, OCW decode or rejected write.
  always_comb begin
    state_nxt = state;
    rej       = 1'b0;
    ld_icw2   = 1'b0;
    ld_icw3   = 1'b0;
    ld_icw4   = 1'b0;
    ocw1      = 1'b0;
    ocw2      = 1'b0;
    ocw3      = 1'b0;
    if (wr_ev) begin
      if (icw1) begin
        state_nxt = W_ICW2;
      end else begin
        case (state)
          IDLE: rej = 1'b1;
          W_ICW2: begin
            if (bus.a0) begin
              ld_icw2   = 1'b1;
              state_nxt = !sngl ? W_ICW3 : (ic4 ? W_ICW4 : READY);
            end else begin
              rej = 1'b1;
            end
          end
          W_ICW3: begin
            if (bus.a0) begin
              ld_icw3   = 1'b1;
              state_nxt = ic4 ? W_ICW4 : READY;
            end else begin
              rej = 1'b1;
            end
          end
          W_ICW4: begin
            if (bus.a0) begin
              ld_icw4   = 1'b1;
              state_nxt = READY;
            end else begin
              rej = 1'b1;
            end
          end
          READY: begin
            // With a0=0 and din[4]=0 the write is OCW2 when din[3]=0 and OCW3 when din[3]=1.
            if (bus.a0)           ocw1 = 1'b1;
            else if (!bus.din[3]) ocw2 = 1'b1;
            else                  ocw3 = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Configuration and command registers, one-cycle pulses, the OCW1 byte index and the poll one-shot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_base   <= '0;
      sngl       <= 1'b0;
      ic4        <= 1'b0;
      ltim       <= 1'b0;
      icw3       <= '0;
      icw4       <= '0;
      imr        <= '0;
      ocw2_cmd   <= '0;
      ocw2_valid <= 1'b0;
      smm        <= 1'b0;
      poll_req   <= 1'b0;
      seq_err    <= 1'b0;
      base_isr   <= 1'b0;
      poll_armed <= 1'b0;
      k          <= '0;
    end else begin
      ocw2_valid <= ocw2;
      poll_req   <= ocw3 & bus.din[2];
      seq_err    <= rej;

      if (icw1) begin
        sngl     <= bus.din[1];
        ic4      <= bus.din[0];
        ltim     <= bus.din[3];
        imr      <= '0;
        smm      <= 1'b0;
        icw3     <= '0;
        icw4     <= '0;
        base_isr <= 1'b0;
      end
      if (ld_icw2) vec_base <= bus.din[7:3];
      if (ld_icw3) icw3     <= bus.din;
      if (ld_icw4) icw4     <= bus.din[4:0];

      if (wr_ev && !bus.a0) begin
        k <= '0;
      end else if (ocw1) begin
        for (int b = 0; b < NB; b++) begin
          if (k == KW'(b)) imr[b*8 +: 8] <= bus.din;
        end
        k <= (k == K_LAST) ? '0 : k + 1'b1;
      end

      if (ocw2) ocw2_cmd <= bus.din;

      if (ocw3) begin
        if (bus.din[6]) smm        <= bus.din[5];
        if (bus.din[1]) base_isr   <= bus.din[0];
        if (bus.din[2]) poll_armed <= 1'b1;
      end

      // A status read with a0=0 consumes an armed poll.
      if (rd_ev && !bus.a0 && poll_armed) poll_armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pic_cmd_decoder.sv
// Directed bench for pic_cmd_decoder with IRQ_W=16 (two OCW1 bytes).
// Outputs are sampled 1ns after the rising edge, so one-cycle pulses are seen once.
// The host bus is driven through the interface's signals from one initial block.
module tb_pic_cmd_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done, sngl, ic4, ltim, ocw2_valid, smm, poll_req, seq_err;
  logic [4:0]  vec_base, icw4;
  logic [7:0]  icw3, ocw2_cmd;
  logic [15:0] imr;
  int          checks = 0;
  int          errors = 0;

  pic_cmd_decoder_if bus ();

  pic_cmd_decoder #(.IRQ_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .init_done(init_done), .vec_base(vec_base), .sngl(sngl), .ic4(ic4), .ltim(ltim),
    .icw3(icw3), .icw4(icw4), .imr(imr), .ocw2_cmd(ocw2_cmd), .ocw2_valid(ocw2_valid),
    .smm(smm), .poll_req(poll_req), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write: strobe falls after an edge, the event is taken on the next edge, then the strobe is released.
  task automatic do_wr(input logic a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.a0 = a; bus.din = d; bus.wr_n = 1'b0;
    @(posedge clk); #1;
    bus.wr_n = 1'b1; bus.cs_n = 1'b1;
  endtask

  initial begin
    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.a0 = 1'b0; bus.din = 8'h00;
    #12;
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_imr", 32'(imr), 0);
    chk("rst_vec_base", 32'(vec_base), 0);
    chk("rst_rd_sel", 32'(bus.rd_sel), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    chk("rst_poll_req", 32'(poll_req), 0);
    rst_n = 1'b1;

    // Non-ICW1 write in IDLE is rejected.
    do_wr(1'b1, 8'hFF);
    chk("idle_seq_err", 32'(seq_err), 1);
    chk("idle_imr", 32'(imr), 0);
    @(posedge clk); #1;
    chk("idle_seq_err_drop", 32'(seq_err), 0);

    // Single, ICW4 required.
    do_wr(1'b0, 8'h13);
    chk("icw1_sngl", 32'(sngl), 1);
    chk("icw1_ic4", 32'(ic4), 1);
    do_wr(1'b1, 8'h20);
    chk("icw2_not_done", 32'(init_done), 0);
    chk("icw2_vec_base", 32'(vec_base), 32'h04);
    do_wr(1'b1, 8'h01);
    chk("icw4_icw4", 32'(icw4), 32'h01);
    chk("icw4_done", 32'(init_done), 1);

    // Cascade init followed by a two-byte mask.
    do_wr(1'b0, 8'h11);
    chk("casc_icw1_not_done", 32'(init_done), 0);
    chk("casc_sngl", 32'(sngl), 0);
    do_wr(1'b1, 8'h08);
    chk("casc_vec_base", 32'(vec_base), 32'h01);
    do_wr(1'b1, 8'h04);
    chk("casc_icw3", 32'(icw3), 32'h04);
    chk("casc_icw3_not_done", 32'(init_done), 0);
    do_wr(1'b1, 8'h01);
    chk("casc_done", 32'(init_done), 1);
    do_wr(1'b1, 8'hAA);
    do_wr(1'b1, 8'h55);
    chk("ocw1_imr_2byte", 32'(imr), 32'h55AA);
    do_wr(1'b1, 8'hFF);
    chk("ocw1_imr_wrap", 32'(imr), 32'h55FF);

    // OCW2 pulse and byte index reset.
    do_wr(1'b0, 8'h20);
    chk("ocw2_valid", 32'(ocw2_valid), 1);
    chk("ocw2_cmd", 32'(ocw2_cmd), 32'h20);
    @(posedge clk); #1;
    chk("ocw2_valid_drop", 32'(ocw2_valid), 0);
    do_wr(1'b1, 8'h12);
    chk("ocw1_after_k_reset", 32'(imr), 32'h5512);

    // OCW3: read ISR.
    do_wr(1'b0, 8'h0B);
    chk("ocw3_rd_sel_isr", 32'(bus.rd_sel), 32'h1);
    bus.a0 = 1'b1; #1;
    chk("ocw3_rd_sel_imr", 32'(bus.rd_sel), 32'h2);

    // Poll command, then one status read consumes it.
    do_wr(1'b0, 8'h0C);
    chk("poll_req", 32'(poll_req), 1);
    @(posedge clk); #1;
    chk("poll_req_drop", 32'(poll_req), 0);
    bus.cs_n = 1'b0; bus.a0 = 1'b0; bus.rd_n = 1'b0; #1;
    chk("poll_rd_sel", 32'(bus.rd_sel), 32'h3);
    @(posedge clk); #1;
    chk("poll_rd_sel_after", 32'(bus.rd_sel), 32'h1);
    bus.rd_n = 1'b1; bus.cs_n = 1'b1;

    do_wr(1'b0, 8'h68);
    chk("smm_set", 32'(smm), 1);

    // Both strobes falling together: ignored.
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h00; bus.wr_n = 1'b0; bus.rd_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("both_low_imr", 32'(imr), 32'h5512);
    chk("both_low_seq_err", 32'(seq_err), 0);
    bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.cs_n = 1'b1;

    // ICW1 while READY re-initialises and clears the mask.
    do_wr(1'b0, 8'h13);
    chk("reinit_imr", 32'(imr), 0);
    chk("reinit_smm", 32'(smm), 0);
    chk("reinit_not_done", 32'(init_done), 0);

    // Non-ICW1 write with a0=0 in W_ICW2 is rejected and the FSM still waits for ICW2.
    do_wr(1'b0, 8'h08);
    chk("wicw2_seq_err", 32'(seq_err), 1);
    do_wr(1'b1, 8'h30);
    chk("wicw2_vec_base", 32'(vec_base), 32'h06);
    chk("wicw2_not_done", 32'(init_done), 0);
    do_wr(1'b1, 8'h03);
    chk("wicw2_icw4", 32'(icw4), 32'h03);
    chk("wicw2_done", 32'(init_done), 1);

    // Asynchronous reset while waiting for ICW3.
    do_wr(1'b0, 8'h11);
    do_wr(1'b1, 8'h08);
    rst_n = 1'b0; #1;
    chk("arst_vec_base", 32'(vec_base), 0);
    chk("arst_icw4", 32'(icw4), 0);
    chk("arst_done", 32'(init_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_wr(1'b1, 8'h04);
    chk("arst_needs_icw1", 32'(seq_err), 1);
    chk("arst_icw3", 32'(icw3), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
